// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage forwarding selects, load-use stall and branch flush control
// Shadows rd/regwrite/memread of in-flight instructions to steer the EX operand muxes.

module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_t;

  stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic luh;

  // A load in EX/MEM has no result yet, so it must not be selected from that stage.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic use_rs,
                                         input stage_t m, input stage_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && m.regwrite && (m.rd != '0) && (m.rd == rs) && !m.memread)
      sel = 2'b10;
    else if (w.regwrite && (w.rd != '0) && (w.rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    luh = ex_q.memread && (ex_q.rd != '0) && id_valid &&
          ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));
    flush_if_id  = ex_branch_taken && !reset;
    stall_if_id  = luh && !flush_if_id && !reset;
    bubble_id_ex = flush_if_id || stall_if_id;
    fwd_a = reset ? 2'b00 : fwd_sel(ex_q.rs1, ex_q.use_rs1, mem_q, wb_q);
    fwd_b = reset ? 2'b00 : fwd_sel(ex_q.rs2, ex_q.use_rs2, mem_q, wb_q);

    ex_d = '0;
    if (id_valid && !bubble_id_ex) begin
      ex_d.valid    = 1'b1;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.use_rs1  = id_use_rs1;
      ex_d.use_rs2  = id_use_rs2;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    cnt_d = cnt_q;
    if (stall_if_id && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  assign stall_count = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed self-checking bench for fwd_hazard_ctrl
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.

module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic [1:0] fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic       stall_if_id, bubble_id_ex, flush_if_id;
  logic       stall_if_id_s, bubble_id_ex_s, flush_if_id_s;
  logic [31:0] stall_count;
  logic [3:0]  stall_count_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_if_id(stall_if_id_s), .bubble_id_ex(bubble_id_ex_s),
    .flush_if_id(flush_if_id_s), .stall_count(stall_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction in ID half a cycle before the edge, then settle.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
    #1;
    chk("no11_a", {31'd0, fwd_a == 2'b11}, 32'd0);
    chk("no11_b", {31'd0, fwd_b == 2'b11}, 32'd0);
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    ex_branch_taken = 1'b1;
    #1;
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("rst_flush", {31'd0, flush_if_id}, 32'd0);
    chk("rst_bubble", {31'd0, bubble_id_ex}, 32'd0);
    chk("rst_count", stall_count, 32'd0);
    ex_branch_taken = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Test 1: reset mid-stream while x5 producer sits in EX/MEM
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    nop();
    chk("pre_rst_fwd_a", {30'd0, fwd_a}, 32'd2);
    reset = 1'b1;
    #1;
    chk("midrst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("midrst_stall", {31'd0, stall_if_id}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    nop();
    chk("post_rst_fwd_a", {30'd0, fwd_a}, 32'd0);

    // Test 2: back-to-back ALU dependency, then one-apart via MEM/WB
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("exmem_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("exmem_fwd_b", {30'd0, fwd_b}, 32'd2);
    nop();
    chk("memwb_fwd_b", {30'd0, fwd_b}, 32'd1);
    chk("memwb_fwd_a", {30'd0, fwd_a}, 32'd0);

    // Test 3: priority of youngest producer, and x0 never forwarded
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    nop();
    chk("prio_fwd_a", {30'd0, fwd_a}, 32'd2);
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    nop();
    chk("x0_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("x0_fwd_b", {30'd0, fwd_b}, 32'd0);
    nop();
    nop();

    // Test 4: load-use pair stalls exactly one cycle
    issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", {31'd0, stall_if_id}, 32'd1);
    chk("lu_bubble", {31'd0, bubble_id_ex}, 32'd1);
    chk("lu_flush", {31'd0, flush_if_id}, 32'd0);
    chk("lu_count0", stall_count, 32'd0);
    issue(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_off", {31'd0, stall_if_id}, 32'd0);
    chk("lu_bubble_off", {31'd0, bubble_id_ex}, 32'd0);
    chk("lu_count1", stall_count, 32'd1);
    nop();
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("lu_count_hold", stall_count, 32'd1);

    // Test 5: unused rs1 match does not stall; branch flush beats load-use
    issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 5'd8, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("nouse_stall", {31'd0, stall_if_id}, 32'd0);
    chk("nouse_bubble", {31'd0, bubble_id_ex}, 32'd0);
    issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("br_flush", {31'd0, flush_if_id}, 32'd1);
    chk("br_stall", {31'd0, stall_if_id}, 32'd0);
    chk("br_bubble", {31'd0, bubble_id_ex}, 32'd1);
    nop();
    chk("br_count", stall_count, 32'd1);
    chk("br_flush_off", {31'd0, flush_if_id}, 32'd0);

    // Test 6: 17 more load-use pairs; 4-bit counter must stop at 15
    for (int i = 0; i < 17; i++) begin
      issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
      issue(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    end
    nop();
    chk("sat_count_wide", stall_count, 32'd18);
    chk("sat_count_narrow", {28'd0, stall_count_s}, 32'd15);
    chk("sat_no11_a", {31'd0, fwd_a_s == 2'b11}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
